// File: rtl/conv_row_sender.sv
// conv_row_sender
//   Transmit side of the convolution-layer row-load interface. On start it
//   captures a ROWS x COLS binary matrix. It then plays the matrix out on one
//   bus as one-cycle row-load strobes, each carrying its row data, followed by
//   an optional zero-data rewind strobe and a compute strobe. Every strobe is
//   followed by GAP_CYCLES all-zero cycles. A one-cycle done pulse marks the end.
//
// Ports
//   clk        in   1          clock, rising edge
//   rst_n      in   1          asynchronous reset, active low
//   start      in   1          pulse; only honoured while idle
//   abort      in   1          synchronous cancel of the current transfer
//   matrix_in  in   ROWS*COLS  row r = matrix_in[r*COLS +: COLS]; sampled on start
//   un_out     out  COLS+2     [COLS+1]=compute strobe, [COLS]=load strobe,
//                              [COLS-1:0]=row data
//   busy       out  1          high from the cycle after start until done
//   done       out  1          one-cycle pulse when the sequence completes
module conv_row_sender #(
  parameter int ROWS       = 6,
  parameter int COLS       = 6,
  parameter int GAP_CYCLES = 1,
  parameter int REWIND     = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [ROWS*COLS-1:0] matrix_in,
  output logic [COLS+1:0]      un_out,
  output logic                 busy,
  output logic                 done
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
  localparam logic [3:0]    GAP_LOAD = 4'(GAP_CYCLES - 1);

  // The state register names what the outputs show in the current cycle:
  // outputs are decoded from the next state and registered alongside it.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_GAP     = 3'd2,
    S_REWIND  = 3'd3,
    S_COMPUTE = 3'd4,
    S_FINISH  = 3'd5
  } state_t;

  state_t                 state_r, state_s;
  state_t                 ret_r, ret_s;       // state entered when a gap ends
  state_t                 follow_s;           // strobe after the current one
  logic [RW-1:0]          row_r, row_s;
  logic [3:0]             gap_r, gap_s;
  logic [ROWS*COLS-1:0]   snap_r;
  logic [ROWS*COLS-1:0]   data_src_s;
  logic                   capture_s;
  logic                   in_xfer_s;
  logic [COLS+1:0]        un_out_s;
  logic                   busy_s;
  logic                   done_s;

  // Next-state, counters and registered-output decode.
  always_comb begin
    state_s    = state_r;
    ret_s      = ret_r;
    row_s      = row_r;
    gap_s      = gap_r;
    capture_s  = 1'b0;
    follow_s   = S_IDLE;
    un_out_s   = {(COLS + 2){1'b0}};
    busy_s     = 1'b0;
    done_s     = 1'b0;

    in_xfer_s = (state_r == S_LOAD) || (state_r == S_GAP) ||
                (state_r == S_REWIND) || (state_r == S_COMPUTE);

    // Which strobe comes after the one currently on the bus.
    case (state_r)
      S_LOAD: begin
        if (row_r == LAST_ROW) begin
          follow_s = (REWIND != 0) ? S_REWIND : S_COMPUTE;
        end else begin
          follow_s = S_LOAD;
        end
      end
      S_REWIND:  follow_s = S_COMPUTE;
      S_COMPUTE: follow_s = S_FINISH;
      default:   follow_s = S_IDLE;
    endcase

    case (state_r)
      S_IDLE: begin
        if (start && !abort) begin
          capture_s = 1'b1;
          row_s     = {RW{1'b0}};
          gap_s     = 4'd0;
          state_s   = S_LOAD;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_LOAD, S_REWIND, S_COMPUTE: begin
        if ((state_r == S_LOAD) && (row_r != LAST_ROW)) begin
          row_s = row_r + RW'(1);
        end else begin
          row_s = row_r;
        end
        if (GAP_CYCLES == 0) begin
          state_s = follow_s;
        end else begin
          state_s = S_GAP;
          ret_s   = follow_s;
          gap_s   = GAP_LOAD;
        end
      end
      S_GAP: begin
        if (gap_r == 4'd0) begin
          state_s = ret_r;
        end else begin
          gap_s = gap_r - 4'd1;
        end
      end
      S_FINISH: begin
        // start here is deliberately dropped; restart only from IDLE
        state_s = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase

    // Cancel wins over every transition; the receiver is left as it is.
    if (abort && in_xfer_s) begin
      state_s = S_IDLE;
      row_s   = {RW{1'b0}};
      gap_s   = 4'd0;
    end else begin
      state_s = state_s;
    end

    // The first row goes out on the capture edge, before the snapshot exists.
    data_src_s = capture_s ? matrix_in : snap_r;

    case (state_s)
      S_LOAD:    un_out_s = {2'b01, data_src_s[row_s*COLS +: COLS]};
      S_REWIND:  un_out_s = {2'b01, {COLS{1'b0}}};
      S_COMPUTE: un_out_s = {2'b10, {COLS{1'b0}}};
      default:   un_out_s = {(COLS + 2){1'b0}};
    endcase

    case (state_s)
      S_LOAD, S_GAP, S_REWIND, S_COMPUTE: busy_s = 1'b1;
      default:                            busy_s = 1'b0;
    endcase

    done_s = (state_s == S_FINISH);
  end

  // State, counters, snapshot and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      ret_r   <= S_IDLE;
      row_r   <= {RW{1'b0}};
      gap_r   <= 4'd0;
      snap_r  <= {(ROWS * COLS){1'b0}};
      un_out  <= {(COLS + 2){1'b0}};
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_r <= state_s;
      ret_r   <= ret_s;
      row_r   <= row_s;
      gap_r   <= gap_s;
      if (capture_s) begin
        snap_r <= matrix_in;
      end
      un_out  <= un_out_s;
      busy    <= busy_s;
      done    <= done_s;
    end
  end

endmodule
